// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

   // FSM encoding: operand capture, chunk-by-chunk addition, result hold.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             busy;

   // Producer/consumer side.
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, s, cout, ovf, busy
   );

   // Adder side.
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, s, cout, ovf, busy
   );
endinterface

// File: rtl/serial_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice built from 1-bit full adders.
module adder_chunk #(
   parameter int unsigned CHUNK = 1
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             cin_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             cout_o,
   output logic             cmsb_o
);

   logic [CHUNK:0] carry;

   // Ripple the carry through each bit; cmsb_o is the carry into the top bit.
   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int k = 0; k < int'(CHUNK); k++) begin
         sum_o[k]     = a_i[k] ^ b_i[k] ^ carry[k];
         carry[k + 1] = (a_i[k] & b_i[k]) | (a_i[k] & carry[k]) | (b_i[k] & carry[k]);
      end
      cout_o = carry[CHUNK];
      cmsb_o = carry[CHUNK-1];
   end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin over WIDTH bits, CHUNK bits per clock, with
// valid/ready handshakes on both sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 1
) (
   input logic           clk,
   input logic           rst_n,
   serial_adder_if.slave bus
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CNT_W  = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
      $error("serial_adder: CHUNK must be >= 1 and divide WIDTH");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0]       chunk_sum;
   logic                   chunk_cout;
   logic                   chunk_cmsb;
   logic [WIDTH+CHUNK-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_shift;

   adder_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a_i    (a_sh_q[CHUNK-1:0]),
      .b_i    (b_sh_q[CHUNK-1:0]),
      .cin_i  (carry_q),
      .sum_o  (chunk_sum),
      .cout_o (chunk_cout),
      .cmsb_o (chunk_cmsb)
   );

   // New sum chunk enters at the MSB end so the LSB chunk ends up at bit 0.
   always_comb begin
      acc_cat   = {chunk_sum, acc_q};
      acc_shift = acc_cat[WIDTH+CHUNK-1:CHUNK];
   end

   // Next-state logic: capture on handshake, add one chunk per CALC cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               a_sh_d  = bus.a;
               b_sh_d  = bus.b;
               carry_d = bus.cin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            a_sh_d  = a_sh_q >> CHUNK;
            b_sh_d  = b_sh_q >> CHUNK;
            carry_d = chunk_cout;
            acc_d   = acc_shift;
            if (cnt_q == LAST_CNT) begin
               // Visible outputs change only here, so they hold the previous result until now.
               s_d     = acc_shift;
               cout_d  = chunk_cout;
               ovf_d   = chunk_cmsb ^ chunk_cout;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Handshake outputs are pure state decodes; no input reaches an output combinationally.
   always_comb begin
      bus.in_ready  = (state_q == StIdle);
      bus.out_valid = (state_q == StDone);
      bus.busy      = (state_q != StIdle);
      bus.s         = s_q;
      bus.cout      = cout_q;
      bus.ovf       = ovf_q;
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed steps plus randomised traffic over several
// WIDTH/CHUNK configurations, with a scoreboard of expected results.
module tb_serial_adder;

   localparam int NI = 10;

   function automatic int unsigned w_of(input int g);
      case (g)
         0: return 8;
         1: return 8;
         2: return 1;
         3: return 8;
         4: return 8;
         5: return 16;
         6: return 16;
         7: return 16;
         8: return 16;
         9: return 16;
         default: return 8;
      endcase
   endfunction

   function automatic int unsigned c_of(input int g);
      case (g)
         0: return 1;
         1: return 4;
         2: return 1;
         3: return 2;
         4: return 8;
         5: return 1;
         6: return 2;
         7: return 4;
         8: return 8;
         9: return 16;
         default: return 1;
      endcase
   endfunction

   typedef struct packed {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic clk;
   logic rst_n;

   logic        in_valid_v  [NI];
   logic [15:0] a_v         [NI];
   logic [15:0] b_v         [NI];
   logic        cin_v       [NI];
   logic        out_ready_v [NI];
   logic        in_ready_v  [NI];
   logic        out_valid_v [NI];
   logic [15:0] s_v         [NI];
   logic        cout_v      [NI];
   logic        ovf_v       [NI];
   logic        busy_v      [NI];

   exp_t sb[$];
   int   ncheck;
   int   npass;
   int   nfail;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned W = w_of(g);
      localparam int unsigned C = c_of(g);
      serial_adder_if #(.WIDTH(W)) bus ();
      assign bus.in_valid   = in_valid_v[g];
      assign bus.a          = a_v[g][W-1:0];
      assign bus.b          = b_v[g][W-1:0];
      assign bus.cin        = cin_v[g];
      assign bus.out_ready  = out_ready_v[g];
      assign in_ready_v[g]  = bus.in_ready;
      assign out_valid_v[g] = bus.out_valid;
      assign s_v[g]         = 16'(bus.s);
      assign cout_v[g]      = bus.cout;
      assign ovf_v[g]       = bus.ovf;
      assign busy_v[g]      = bus.busy;
      serial_adder #(
         .WIDTH (W),
         .CHUNK (C)
      ) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncheck++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result sign bits.
   function automatic exp_t model(input int unsigned w, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin);
      exp_t        r;
      logic [16:0] mask;
      logic [16:0] am;
      logic [16:0] bm;
      logic [16:0] sum;
      mask  = (17'd1 << w) - 17'd1;
      am    = {1'b0, a} & mask;
      bm    = {1'b0, b} & mask;
      sum   = am + bm + {16'd0, cin};
      r.s   = sum[15:0] & mask[15:0];
      r.c   = sum[w];
      r.o   = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
      return r;
   endfunction

   // One directed operation with explicit expected values. hold = DONE cycles with
   // out_ready low (an in_valid pulse is injected). ovl = retire with next operands valid.
   task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec,
                         input logic eo, input int hold, input logic ovl,
                         input logic [15:0] na, input logic [15:0] nb, input logic ncin);
      int          n;
      int          lat;
      logic [15:0] s_hold;
      exp_t        e;
      a_v[i]        = a;
      b_v[i]        = b;
      cin_v[i]      = cin;
      in_valid_v[i] = 1'b1;
      n = 0;
      while (!in_ready_v[i] && n < 50) begin
         step();
         n++;
      end
      check("accept_ready", in_ready_v[i], 1);
      step();
      sb.push_back('{s: es, c: ec, o: eo});
      in_valid_v[i] = 1'b0;
      a_v[i]        = ~a;
      b_v[i]        = ~b;
      cin_v[i]      = ~cin;
      check("calc_busy", busy_v[i], 1);
      check("calc_in_ready", in_ready_v[i], 0);
      lat = 0;
      while (!out_valid_v[i] && lat < 100) begin
         step();
         lat++;
      end
      check("latency", lat, w_of(i) / c_of(i));
      s_hold = s_v[i];
      for (int h = 0; h < hold; h++) begin
         in_valid_v[i] = (h == 1);
         a_v[i]        = 16'h0011;
         step();
         check("hold_out_valid", out_valid_v[i], 1);
         check("hold_s_stable", s_v[i], s_hold);
         check("hold_in_ready", in_ready_v[i], 0);
      end
      in_valid_v[i] = 1'b0;
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("res_s", s_v[i], e.s);
         check("res_cout", cout_v[i], e.c);
         check("res_ovf", ovf_v[i], e.o);
      end
      out_ready_v[i] = 1'b1;
      if (ovl) begin
         a_v[i]        = na;
         b_v[i]        = nb;
         cin_v[i]      = ncin;
         in_valid_v[i] = 1'b1;
      end
      step();
      out_ready_v[i] = 1'b0;
      check("retire_out_valid", out_valid_v[i], 0);
      check("retire_in_ready", in_ready_v[i], 1);
      check("retire_busy", busy_v[i], 0);
      check("retire_s_held", s_v[i], es);
      if (hold > 0) begin
         step();
         check("pulse_ignored", busy_v[i], 0);
      end
   endtask

   // Randomised back-to-back traffic with random out_ready on instance i.
   task automatic rand_run(input int i, input int nops);
      int          issued;
      int          retired;
      int          cyc;
      logic        fire_in;
      logic        fire_out;
      logic [15:0] obs_s;
      logic        obs_c;
      logic        obs_o;
      exp_t        e;
      sb.delete();
      issued  = 0;
      retired = 0;
      cyc     = 0;
      while (retired < nops && cyc < 40 * nops + 200) begin
         if (!in_valid_v[i] && issued < nops && $urandom_range(0, 1) == 1) begin
            a_v[i]        = 16'($urandom);
            b_v[i]        = 16'($urandom);
            cin_v[i]      = 1'($urandom_range(0, 1));
            in_valid_v[i] = 1'b1;
         end
         out_ready_v[i] = ($urandom_range(0, 2) != 0);
         fire_in  = in_valid_v[i] && in_ready_v[i];
         fire_out = out_valid_v[i] && out_ready_v[i];
         obs_s    = s_v[i];
         obs_c    = cout_v[i];
         obs_o    = ovf_v[i];
         if (fire_in) begin
            sb.push_back(model(w_of(i), a_v[i], b_v[i], cin_v[i]));
         end
         step();
         cyc++;
         if (fire_in) begin
            issued++;
            in_valid_v[i] = 1'b0;
            a_v[i]        = 16'($urandom);
            b_v[i]        = 16'($urandom);
         end
         if (fire_out) begin
            check("rnd_sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("rnd_s", obs_s, e.s);
               check("rnd_cout", obs_c, e.c);
               check("rnd_ovf", obs_o, e.o);
            end
            retired++;
         end
      end
      check("rnd_retired", retired, nops);
      check("rnd_leftover", sb.size(), 0);
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
      step();
   endtask

   initial begin
      int   n;
      logic seen;
      ncheck = 0;
      npass  = 0;
      nfail  = 0;
      for (int i = 0; i < NI; i++) begin
         in_valid_v[i]  = 1'b0;
         a_v[i]         = '0;
         b_v[i]         = '0;
         cin_v[i]       = 1'b0;
         out_ready_v[i] = 1'b0;
      end
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      step();
      step();
      check("rst_in_ready", in_ready_v[0], 1);
      check("rst_out_valid", out_valid_v[0], 0);
      check("rst_s", s_v[0], 0);
      check("rst_cout", cout_v[0], 0);
      check("rst_ovf", ovf_v[0], 0);
      check("rst_busy", busy_v[0], 0);
      rst_n = 1'b1;
      step();

      // Zero operands.
      run_op(0, 16'h00, 16'h00, 1'b0, 16'h00, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0);
      // Carry out; retire while the next operands are already valid.
      run_op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, 0, 1'b1, 16'h7F, 16'h00, 1'b1);
      // Signed overflow via carry-in.
      run_op(0, 16'h7F, 16'h00, 1'b1, 16'h80, 1'b0, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
      // Backpressure for 5 cycles in DONE.
      run_op(0, 16'h35, 16'h4A, 1'b0, 16'h7F, 1'b0, 1'b0, 5, 1'b0, 16'h0, 16'h0, 1'b0);

      // Reset after 3 of 8 chunks.
      a_v[0]        = 16'hC3;
      b_v[0]        = 16'h3C;
      cin_v[0]      = 1'b1;
      in_valid_v[0] = 1'b1;
      step();
      in_valid_v[0] = 1'b0;
      check("mid_busy", busy_v[0], 1);
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready_v[0], 1);
      check("midrst_out_valid", out_valid_v[0], 0);
      check("midrst_s", s_v[0], 0);
      check("midrst_cout", cout_v[0], 0);
      check("midrst_ovf", ovf_v[0], 0);
      check("midrst_busy", busy_v[0], 0);
      sb.delete();
      step();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (n = 0; n < 12; n++) begin
         step();
         if (out_valid_v[0]) seen = 1'b1;
      end
      check("midrst_no_out_valid", seen, 0);
      run_op(0, 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0);

      // WIDTH=8, CHUNK=4.
      run_op(1, 16'hA5, 16'h5A, 1'b1, 16'h00, 1'b1, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0);
      // WIDTH=1 and full-width single-chunk edge cases.
      run_op(2, 16'h1, 16'h1, 1'b0, 16'h0, 1'b1, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);
      run_op(9, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0);

      for (int i = 0; i < NI; i++) begin
         rand_run(i, 25);
      end

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule
